// File: rtl/trojan_trigger_pkg.sv
// Shared types and constants for the multi-mode trigger unit.
// States, mode selectors and trigger_src bit positions.
package trojan_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

    localparam logic [1:0] MODE_TIME = 2'd0;
    localparam logic [1:0] MODE_EVT  = 2'd1;
    localparam logic [1:0] MODE_SEQ  = 2'd2;
    localparam logic [1:0] MODE_ANY  = 2'd3;

    localparam int SRC_TIME = 0;
    localparam int SRC_EVT  = 1;
    localparam int SRC_SEQ  = 2;

    // Which trigger_src bits a given mode allows to fire.
    function automatic logic [2:0] mode_mask(input logic [1:0] mode);
        logic [2:0] m;
        m = '0;
        unique case (mode)
            MODE_TIME: m[SRC_TIME] = 1'b1;
            MODE_EVT:  m[SRC_EVT]  = 1'b1;
            MODE_SEQ:  m[SRC_SEQ]  = 1'b1;
            default:   m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/trojan_seq_matcher.sv
// Tracks progress through a fixed data pattern on a qualified bus.
// Only a restart on element 0 is recognised after a mismatch.
module trojan_seq_matcher
    import trojan_trigger_pkg::*;
#(
    parameter int                        DATA_W      = 8,
    parameter int                        SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*DATA_W-1:0] SEQ_PATTERN = 32'h44_33_22_11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_hit
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] w_elem;
    logic [DATA_W-1:0] w_first;
    logic              w_match;
    logic              w_last;

    assign w_elem  = SEQ_PATTERN[DATA_W*int'(r_idx) +: DATA_W];
    assign w_first = SEQ_PATTERN[DATA_W-1:0];
    assign w_match = (i_data == w_elem);
    assign w_last  = (r_idx == IDX_W'(SEQ_LEN - 1));
    assign o_hit   = i_en & i_valid & w_match & w_last;

    // Advance on a matching beat, restart at 0 or 1 on a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en && i_valid) begin
            if (w_match)
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            else if (i_data == w_first)
                r_idx <= IDX_W'(1);
            else
                r_idx <= '0;
        end
    end

endmodule

// File: rtl/trojan_trigger_unit.sv
// Time / event / sequence trigger with arm, clear and sticky or pulse output.
// All outputs come straight from registers; fire latency is one edge.
module trojan_trigger_unit
    import trojan_trigger_pkg::*;
#(
    parameter int                        CNT_W       = 32,
    parameter int unsigned               TIME_THRESH = 2500,
    parameter int unsigned               EVT_THRESH  = 16,
    parameter int                        DATA_W      = 8,
    parameter int                        SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*DATA_W-1:0] SEQ_PATTERN = 32'h44_33_22_11,
    parameter bit                        STICKY      = 1'b1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              arm,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              event_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              trigger,
    output logic [2:0]        trigger_src,
    output logic              armed
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ARMED = 2'(ST_ARMED);
    localparam logic [1:0] S_FIRED = 2'(ST_FIRED);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_evt_cnt;
    logic             r_evt_prev;
    logic             r_trigger;
    logic [2:0]       r_src;

    logic             w_armed;
    logic             w_idle;
    logic             w_rise;
    logic             w_hit_seq;
    logic [2:0]       w_hits;
    logic [2:0]       w_fire_src;
    logic             w_fire;

    assign w_armed = (r_state == S_ARMED);
    assign w_idle  = (r_state == S_IDLE);
    assign w_rise  = event_in & ~r_evt_prev;

    assign w_hits[SRC_TIME] = w_armed &&
        (r_cyc_cnt == CNT_W'(TIME_THRESH - 1));
    assign w_hits[SRC_EVT]  = w_armed && w_rise &&
        (r_evt_cnt == CNT_W'(EVT_THRESH - 1));
    assign w_hits[SRC_SEQ]  = w_hit_seq;

    assign w_fire_src = w_hits & mode_mask(mode);
    assign w_fire     = |w_fire_src;

    assign trigger     = r_trigger;
    assign trigger_src = r_src;
    assign armed       = w_armed;

    trojan_seq_matcher #(
        .DATA_W      (DATA_W),
        .SEQ_LEN     (SEQ_LEN),
        .SEQ_PATTERN (SEQ_PATTERN)
    ) u_seq (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .i_en    (w_armed),
        .i_clr   (clear | w_idle),
        .i_valid (data_valid),
        .i_data  (data_in),
        .o_hit   (w_hit_seq)
    );

    // Previous event_in level for rising-edge detection, in every state.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)
            r_evt_prev <= 1'b0;
        else
            r_evt_prev <= event_in;
    end

    // Saturating cycle and event counters: zero in IDLE, frozen in FIRED.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_cyc_cnt <= '0;
            r_evt_cnt <= '0;
        end else if (clear || w_idle) begin
            r_cyc_cnt <= '0;
            r_evt_cnt <= '0;
        end else if (w_armed) begin
            if (r_cyc_cnt != '1)
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            if (w_rise && (r_evt_cnt != '1))
                r_evt_cnt <= r_evt_cnt + CNT_W'(1);
        end
    end

    // Control FSM: clear beats fire and arm; src holds until next fire.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state   <= S_IDLE;
            r_trigger <= 1'b0;
            r_src     <= '0;
        end else if (clear) begin
            r_state   <= S_IDLE;
            r_trigger <= 1'b0;
            r_src     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_trigger <= 1'b0;
                    if (arm)
                        r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_fire) begin
                        r_state   <= S_FIRED;
                        r_trigger <= 1'b1;
                        r_src     <= w_fire_src;
                    end
                end
                S_FIRED: begin
                    if (STICKY) begin
                        r_trigger <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_trigger <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_trigger <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trojan_trigger_unit.sv
// Scoreboard bench: three trigger variants share one random-ish stimulus.
// A per-instance reference model predicts outputs; a monitor checks them.
module tb_trojan_trigger_unit;

    localparam int unsigned TA = 2500;
    localparam int unsigned TB = 40;
    localparam int unsigned TC = 31;
    localparam longint      CMAX = 64'hFFFF_FFFF;

    typedef struct {
        int     ph;
        longint cyc;
        longint evt;
        int     idx;
        bit     prev;
        bit     trig;
        bit [2:0] src;
    } mdl_t;

    typedef struct {
        int         tag;
        int         inst;
        logic [4:0] v;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic       arm;
    logic       clr;
    logic [1:0] mode;
    logic       ev;
    logic [7:0] d;
    logic       dv;

    logic       trg   [3];
    logic [2:0] src   [3];
    logic       arm_o [3];

    int          cyc;
    int          n_cmp;
    int          n_bad;
    mdl_t        m  [3];
    int unsigned tt [3];
    bit          st [3];
    logic [7:0]  pat [4];
    sb_t         sb [$];

    trojan_trigger_unit u_a (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .arm(arm), .clear(clr),
        .mode(mode), .event_in(ev), .data_in(d), .data_valid(dv),
        .trigger(trg[0]), .trigger_src(src[0]), .armed(arm_o[0])
    );

    trojan_trigger_unit #(.TIME_THRESH(TB), .STICKY(1'b0)) u_b (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .arm(arm), .clear(clr),
        .mode(mode), .event_in(ev), .data_in(d), .data_valid(dv),
        .trigger(trg[1]), .trigger_src(src[1]), .armed(arm_o[1])
    );

    trojan_trigger_unit #(.TIME_THRESH(TC)) u_c (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .arm(arm), .clear(clr),
        .mode(mode), .event_in(ev), .data_in(d), .data_valid(dv),
        .trigger(trg[2]), .trigger_src(src[2]), .armed(arm_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to align scoreboard entries with edges.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] obs(input int i);
        return {trg[i], src[i], arm_o[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h",
                     name, cyc, got, exp);
        end
    endtask

    // Behaviour of one unit over one clock edge, from the stated rules.
    function automatic mdl_t step(input mdl_t mi, input int unsigned t,
                                  input bit sticky);
        mdl_t       r;
        bit         rise, ht, he, hs;
        logic [2:0] en, f;
        r = mi;
        if (!rst_n) begin
            r.ph = 0; r.cyc = 0; r.evt = 0; r.idx = 0;
            r.prev = 0; r.trig = 0; r.src = 0;
            return r;
        end
        rise = ev && !r.prev;
        r.prev = ev;
        ht = 0; he = 0; hs = 0;
        if (clr) begin
            r.ph = 0; r.cyc = 0; r.evt = 0; r.idx = 0;
            r.trig = 0; r.src = 0;
        end else if (r.ph == 0) begin
            r.trig = 0; r.cyc = 0; r.evt = 0; r.idx = 0;
            if (arm) r.ph = 1;
        end else if (r.ph == 1) begin
            if (r.cyc < CMAX) r.cyc++;
            ht = (r.cyc == longint'(t));
            if (rise && r.evt < CMAX) begin
                r.evt++;
                he = (r.evt == 16);
            end
            if (dv) begin
                if (d == pat[r.idx]) begin
                    if (r.idx == 3) begin
                        hs = 1;
                        r.idx = 0;
                    end else begin
                        r.idx++;
                    end
                end else begin
                    r.idx = (d == pat[0]) ? 1 : 0;
                end
            end
            case (mode)
                2'd0:    en = 3'b001;
                2'd1:    en = 3'b010;
                2'd2:    en = 3'b100;
                default: en = 3'b111;
            endcase
            f = {hs, he, ht} & en;
            if (f != 0) begin
                r.ph = 2; r.trig = 1; r.src = f;
            end
        end else begin
            if (sticky) begin
                r.trig = 1;
            end else begin
                r.ph = 0; r.trig = 0; r.cyc = 0; r.evt = 0; r.idx = 0;
            end
        end
        return r;
    endfunction

    // Predict the next edge for every instance, then advance one cycle.
    task automatic commit();
        sb_t e;
        for (int i = 0; i < 3; i++) begin
            m[i]  = step(m[i], tt[i], st[i]);
            e.tag = cyc + 1;
            e.inst = i;
            e.v   = {m[i].trig, m[i].src, m[i].ph == 1};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) commit();
    endtask

    task automatic do_clear();
        clr = 1; arm = 0; ev = 0; dv = 0;
        commit();
        clr = 0;
        commit();
    endtask

    task automatic beat(input logic v, input logic [7:0] x);
        dv = v; d = x;
        commit();
    endtask

    task automatic evt_burst(input bit fire_exp);
        ev = 1; run(5);
        ev = 0; run(1);
        for (int k = 1; k <= 16; k++) begin
            ev = 1;
            commit();
            if (fire_exp && k == 14) chk("evt_pre", obs(0), 5'b0_000_1);
            if (fire_exp && k == 15) chk("evt_fire", obs(0), 5'b1_010_0);
            ev = 0;
            commit();
        end
        if (!fire_exp) chk("evt_mode0_nofire", obs(0), 5'b0_000_1);
    endtask

    // Monitor: compare every prediction due at this falling edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                chk($sformatf("sb_inst%0d", e.inst), 32'(obs(e.inst)),
                    32'(e.v));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        tt[0] = TA; tt[1] = TB; tt[2] = TC;
        st[0] = 1;  st[1] = 0;  st[2] = 1;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            m[i].ph = 0; m[i].cyc = 0; m[i].evt = 0; m[i].idx = 0;
            m[i].prev = 0; m[i].trig = 0; m[i].src = 0;
        end
        rst_n = 0; arm = 0; clr = 0; mode = 0; ev = 0; d = 0; dv = 0;
        @(posedge clk);
        #1;
        arm = 1;
        commit();
        chk("reset_A", obs(0), 5'b0);
        chk("reset_B", obs(1), 5'b0);
        run(2);
        rst_n = 1; arm = 0;
        run(2);

        // Time mode on defaults, with noise on the masked inputs.
        mode = 0; arm = 1;
        commit();
        arm = 0;
        for (int j = 1; j <= 2500; j++) begin
            ev = 1'($urandom); dv = 1'($urandom); d = 8'($urandom);
            commit();
            if (j == 2499) chk("time_pre", obs(0), 5'b0_000_1);
            if (j == 2500) chk("time_fire", obs(0), 5'b1_001_0);
        end
        for (int j = 0; j < 10000; j++) begin
            ev = 1'($urandom); dv = 1'($urandom); d = 8'($urandom);
            commit();
        end
        chk("time_sticky_hold", obs(0), 5'b1_001_0);
        do_clear();
        chk("clear_idle", obs(0), 5'b0);

        // Event mode, then the same burst in time mode.
        mode = 1; arm = 1;
        commit();
        arm = 0;
        evt_burst(1'b1);
        do_clear();
        mode = 0; arm = 1;
        commit();
        arm = 0;
        evt_burst(1'b0);
        do_clear();

        // Sequence mode with a broken prefix, gaps and an overlap.
        mode = 2; arm = 1;
        commit();
        arm = 0;
        beat(1, 8'h11); beat(1, 8'h22); beat(1, 8'h55);
        beat(1, 8'h33); beat(1, 8'h44);
        chk("seq_reset_idx", obs(0), 5'b0_000_1);
        beat(1, 8'h11); beat(0, 8'h99); beat(1, 8'h22);
        beat(1, 8'h11); beat(1, 8'h22); beat(1, 8'h33);
        beat(0, 8'h44);
        chk("seq_pre", obs(0), 5'b0_000_1);
        beat(1, 8'h44);
        chk("seq_fire", obs(0), 5'b1_100_0);
        dv = 0;
        run(3);
        do_clear();

        // Any-of mode: time and 16th event coincide on unit C.
        mode = 3; arm = 1;
        commit();
        arm = 0;
        for (int k = 1; k <= 16; k++) begin
            ev = 1;
            commit();
            if (k == 16) begin
                chk("any_C_src", obs(2), 5'b1_011_0);
                chk("any_A_src", obs(0), 5'b1_010_0);
            end
            ev = 0;
            commit();
        end
        do_clear();

        // Pulse mode on unit B, then re-arm from zero.
        mode = 0; arm = 1;
        commit();
        arm = 0;
        for (int j = 1; j <= 42; j++) begin
            commit();
            if (j == 39) chk("pulse_pre", obs(1), 5'b0_000_1);
            if (j == 40) chk("pulse_fire", obs(1), 5'b1_001_0);
            if (j == 41) chk("pulse_drop", obs(1), 5'b0_001_0);
        end
        arm = 1;
        commit();
        chk("pulse_rearm", obs(1), 5'b0_001_1);
        arm = 0;
        for (int j = 1; j <= 40; j++) begin
            commit();
            if (j == 39) chk("rearm_pre", obs(1), 5'b0_001_1);
            if (j == 40) chk("rearm_fire", obs(1), 5'b1_001_0);
        end
        do_clear();

        // Clear on the same edge as B's time fire.
        mode = 0; arm = 1;
        commit();
        arm = 0;
        run(39);
        clr = 1;
        commit();
        chk("clear_vs_fire", obs(1), 5'b0);
        clr = 0;
        run(3);
        chk("clear_stays_idle", obs(1), 5'b0);

        // Asynchronous reset in the middle of ARMED.
        arm = 1;
        commit();
        arm = 0;
        run(1200);
        rst_n = 0;
        #1;
        chk("async_rst_A", obs(0), 5'b0);
        for (int i = int'(sb.size()) - 1; i >= 0; i--)
            if (sb[i].tag == cyc) sb.delete(i);
        run(2);
        rst_n = 1;
        run(1);
        arm = 1;
        commit();
        arm = 0;
        for (int j = 1; j <= 2500; j++) begin
            commit();
            if (j == 2499) chk("rst_rearm_pre", obs(0), 5'b0_000_1);
            if (j == 2500) chk("rst_rearm_fire", obs(0), 5'b1_001_0);
        end
        do_clear();

        // Random traffic checked only through the scoreboard.
        for (int j = 0; j < 3000; j++) begin
            clr = ($urandom_range(199) == 0);
            arm = ($urandom_range(19) == 0);
            if ($urandom_range(299) == 0) mode = 2'($urandom);
            ev = ($urandom_range(2) == 0) ? ~ev : ev;
            dv = 1'($urandom);
            d  = ($urandom_range(3) != 0) ? pat[$urandom_range(3)]
                                          : 8'($urandom);
            commit();
        end
        do_clear();
        run(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
